// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_e      - loader FSM states
//   SYNC_BYTE    - frame start marker
//   DEF_ADDR_W   - default memory address width (4 KiB store)
//   DEF_DATA_W   - default byte / stream width
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         DEF_ADDR_W = 12;
  localparam int         DEF_DATA_W = 8;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: 2^ADDR_W x DATA_W byte store with one synchronous write port and a
// combinational 4-byte big-endian read whose byte addresses wrap modulo the depth.
//   clk_i    - clock (write port)
//   we_i     - write enable
//   waddr_i  - write byte address
//   wdata_i  - write byte
//   raddr_i  - read base byte address
//   rdata_o  - {mem[a], mem[a+1], mem[a+2], mem[a+3]}
// Contents are intentionally not reset.
module imem_ram
  import loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [4*DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // ADDR_W-bit sums wrap naturally, giving the modulo-depth read.
  logic [ADDR_W-1:0] raddr1, raddr2, raddr3;
  assign raddr1 = raddr_i + ADDR_W'(1);
  assign raddr2 = raddr_i + ADDR_W'(2);
  assign raddr3 = raddr_i + ADDR_W'(3);

  assign rdata_o = {mem_q[raddr_i], mem_q[raddr1], mem_q[raddr2], mem_q[raddr3]};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory filled by a framed byte stream.
// Frame: SYNC(0xA5), LEN_HI, LEN_LO, N payload bytes, CSUM (XOR of payload).
// Payload byte k lands at mem[k]; on checksum match the CPU is released.
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   byte_i           - stream byte
//   byte_valid_i     - byte_i valid
//   byte_ready_o     - loader can accept a byte (registered)
//   a_i              - fetch byte address (low ADDR_W bits used)
//   rd_o             - big-endian instruction word at a_i (combinational)
//   load_done_o      - image loaded, checksum matched
//   err_o            - frame error (bad length or checksum)
//   cpu_run_o        - CPU may run; mirrors load_done_o
//   dbg_state_o      - current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1; byte_i must be stable while byte_valid_i is 1 and
// nothing is consumed in a cycle where either is 0.
module imem_loader
  import loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic [WIDTH-1:0]  a_i,
  output logic [WIDTH-1:0]  rd_o,
  output logic              load_done_o,
  output logic              err_o,
  output logic              cpu_run_o,
  output logic [2:0]        dbg_state_o
);

  localparam int LEN_W = 2 * DATA_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [DATA_W-1:0]  len_hi_q, len_hi_d;
  logic [DATA_W-1:0]  csum_q, csum_d;
  logic               ready_q, done_q, err_q;

  logic               xfer;
  logic               we;
  logic [LEN_W-1:0]   len_full;
  logic [ADDR_W:0]    ptr_inc;

  assign xfer     = byte_valid_i & ready_q;
  assign len_full = {len_hi_q, byte_i};
  assign ptr_inc  = ptr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    len_hi_d = len_hi_q;
    csum_d   = csum_q;
    we       = 1'b0;
    if (xfer) begin
      case (state_q)
        IDLE, ERR: begin
          if (byte_i == DATA_W'(SYNC_BYTE)) begin
            state_d = LEN_HI;
            csum_d  = '0;
          end
        end
        LEN_HI: begin
          len_hi_d = byte_i;
          state_d  = LEN_LO;
        end
        LEN_LO: begin
          if (len_full == '0 || len_full > MAX_LEN) begin
            state_d = ERR;
          end else begin
            len_d   = len_full[ADDR_W:0];
            ptr_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          we     = 1'b1;
          csum_d = csum_q ^ byte_i;
          ptr_d  = ptr_inc;
          if (ptr_inc == len_q) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          state_d = (byte_i == csum_q) ? DONE : ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output flags are registered from the next state so they appear in the
  // cycle right after the deciding byte is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      len_hi_q <= '0;
      csum_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      len_hi_q <= len_hi_d;
      csum_q   <= csum_d;
      ready_q  <= (state_d != DONE);
      done_q   <= (state_d == DONE);
      err_q    <= (state_d == ERR);
    end
  end

  logic [4*DATA_W-1:0] rdata;

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (ptr_q[ADDR_W-1:0]),
    .wdata_i (byte_i),
    .raddr_i (a_i[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  // Upper fetch address bits are ignored by design.
  logic unused_addr;
  assign unused_addr = ^a_i[WIDTH-1:ADDR_W];

  assign rd_o         = WIDTH'(rdata);
  assign byte_ready_o = ready_q;
  assign load_done_o  = done_q;
  assign cpu_run_o    = done_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] a_in = 32'h0;
  logic [31:0] rd;
  logic        load_done, err, cpu_run;
  logic [2:0]  dbg_state;

  imem_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_i       (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready),
    .a_i          (a_in),
    .rd_o         (rd),
    .load_done_o  (load_done),
    .err_o        (err),
    .cpu_run_o    (cpu_run),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];        // expected {load_done, err} at each outcome event
  int last_acc = 0;            // cycle count after the most recent accepted byte
  logic [7:0] pay_q[$];
  logic [7:0] model_mem [4096];
  logic       known [4096];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
      prev_err  <= 1'b0;
    end else begin
      if ((load_done && !prev_done) || (err && !prev_err)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_outcome: got done=%0b err=%0b with nothing expected", load_done, err);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("outcome", {30'b0, load_done, err}, {30'b0, e});
          chk("outcome_latency", cyc - last_acc, 0);
          chk("cpu_run_eq_done", {31'b0, cpu_run}, {31'b0, load_done});
        end
      end
      prev_done <= load_done;
      prev_err  <= err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, byte_ready}, 32'd1);
    chk({tag, "_done"},  {31'b0, load_done},  32'd0);
    chk({tag, "_err"},   {31'b0, err},        32'd0);
    chk({tag, "_run"},   {31'b0, cpu_run},    32'd0);
  endtask

  // Caller is aligned to #1 after a rising edge; returns likewise.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int waited;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    waited = 0;
    while (!byte_ready) begin
      @(posedge clk);
      #1;
      waited++;
      if (waited > 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout: byte %02h not accepted within 64 cycles", b);
        byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    byte_valid = 1'b0;
  endtask

  // Sends a whole frame with payload pay_q[0..n-1]; csum_xor != 0 corrupts CSUM.
  task automatic send_frame(input int n, input logic [7:0] csum_xor, input int gap);
    logic [7:0]  cs;
    logic [15:0] nl;
    cs = 8'h00;
    nl = n[15:0];
    send_byte(8'hA5, gap);
    send_byte(nl[15:8], gap);
    if (n < 1 || n > 4096) begin
      exp_q.push_back(2'b01);
      send_byte(nl[7:0], gap);
      return;
    end
    send_byte(nl[7:0], gap);
    for (int k = 0; k < n; k++) begin
      cs = cs ^ pay_q[k];
      model_mem[k] = pay_q[k];
      known[k] = 1'b1;
      send_byte(pay_q[k], gap);
    end
    exp_q.push_back((csum_xor == 8'h00) ? 2'b10 : 2'b01);
    send_byte(cs ^ csum_xor, gap);
  endtask

  task automatic wait_outcome(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_outcome_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_read(input logic [31:0] addr);
    logic [31:0] e;
    int base;
    bit all_known;
    a_in = addr;
    #1;
    base = int'(addr & 32'h0000_0FFF);
    all_known = 1'b1;
    e = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (!known[(base + k) % 4096]) all_known = 1'b0;
      e = {e[23:0], model_mem[(base + k) % 4096]};
    end
    if (all_known) chk("fetch_word", rd, e);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;

    // Reset state
    do_reset();
    check_reset_vals("reset");

    // Basic frame preceded by junk
    send_byte(8'h3C, 0);
    send_byte(8'h00, 0);
    pay_q = '{8'h00, 8'h10, 8'h00, 8'h93};
    send_frame(4, 8'h00, 0);
    wait_outcome("basic");
    a_in = 32'h0;
    #1;
    chk("basic_rd0", rd, 32'h0010_0093);
    chk("basic_ready_low", {31'b0, byte_ready}, 32'd0);
    chk("basic_run", {31'b0, cpu_run}, 32'd1);

    // Bad checksum then recovery without reset
    do_reset();
    check_reset_vals("reset2");
    send_frame(4, 8'h07, 0);   // CSUM 0x84
    wait_outcome("badcsum");
    chk("badcsum_run", {31'b0, cpu_run}, 32'd0);
    chk("badcsum_err", {31'b0, err}, 32'd1);
    send_frame(4, 8'h00, 0);
    wait_outcome("recover");
    chk("recover_err", {31'b0, err}, 32'd0);
    chk("recover_done", {31'b0, load_done}, 32'd1);

    // Length errors; following bytes must not touch memory
    do_reset();
    send_frame(0, 8'h00, 0);
    wait_outcome("len0");
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    check_read(32'h0);
    chk("len0_err", {31'b0, err}, 32'd1);
    send_frame(16'h1001, 8'h00, 0);
    wait_outcome("len4097");
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    check_read(32'h0);
    chk("len4097_err", {31'b0, err}, 32'd1);
    chk("len4097_done", {31'b0, load_done}, 32'd0);

    // Full 4 KiB image with random gaps
    do_reset();
    pay_q.delete();
    for (int i = 0; i < 4096; i++) pay_q.push_back(8'(i % 256));
    send_frame(4096, 8'h00, 20);
    wait_outcome("full");
    a_in = 32'h0000_0FFE;
    #1;
    chk("wrap_ffe", rd, 32'hFEFF_0001);
    a_in = 32'hFFFF_F004;
    #1;
    chk("upper_bits_ignored", rd, 32'h0405_0607);
    for (int i = 0; i < 8; i++) check_read($urandom);

    // Random frames: random length, gaps, checksum corruption, bad lengths
    for (int it = 0; it < 8; it++) begin
      int n, sel, gap;
      logic [7:0] cx;
      do_reset();
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(4097, 65535);
      else               n = $urandom_range(1, 300);
      cx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      gap = $urandom_range(0, 60);
      pay_q.delete();
      for (int k = 0; k < 300; k++) pay_q.push_back(8'($urandom));
      send_frame(n, cx, gap);
      wait_outcome("rand");
      for (int r = 0; r < 6; r++) check_read($urandom);
    end

    // Reset mid-payload, then a fresh frame
    do_reset();
    pay_q.delete();
    for (int k = 0; k < 8; k++) pay_q.push_back(8'($urandom));
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    for (int k = 0; k < 3; k++) begin
      model_mem[k] = pay_q[k];
      known[k] = 1'b1;
      send_byte(pay_q[k], 0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_read(32'h0);
    pay_q.delete();
    for (int k = 0; k < 8; k++) pay_q.push_back(8'($urandom));
    send_frame(8, 8'h00, 30);
    wait_outcome("after_midreset");
    chk("after_midreset_done", {31'b0, load_done}, 32'd1);
    for (int k = 0; k < 8; k++) check_read(32'(k));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
